inst_sequencer: RTL and testbench

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/inst_sequencer_pkg.sv | 44 ++++
 rtl/inst_sequencer.sv | 127 ++++++++++++
 tb/tb_inst_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_sequencer_pkg
//  Description : Shared types and constants for the tile instruction
//                sequencer and the corelet that consumes its inst_q word.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_sequencer_pkg;

    // Width of the instruction word sent to the corelet
    localparam int INST_W   = 34;

    // Bit positions inside the instruction word
    localparam int LOAD     = 0;
    localparam int EXEC     = 1;
    localparam int L0_WR    = 2;
    localparam int L0_RD    = 3;
    localparam int OFIFO_RD = 6;

    // Sequencer phases, in the order a tile walks through them
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KFILL = 3'd1,
        S_KLOAD = 3'd2,
        S_GAP   = 3'd3,
        S_AFILL = 3'd4,
        S_EXEC  = 3'd5,
        S_DRAIN = 3'd6,
        S_DONE  = 3'd7
    } seq_state_t;

    // Phase counter width: large enough for the longest phase (kernel load
    // of col vectors, L0 depth of row entries, or up to 2^len_bw-1 vectors)
    // plus one spare bit.
    function automatic int cnt_width(input int n_row, input int n_col, input int n_len_bw);
        int span;
        span = 1 << n_len_bw;
        if (n_col > span) span = n_col;
        if (n_row > span) span = n_row;
        return $clog2(span) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : inst_sequencer
//  Description : Issues the per-cycle instruction word that runs one tile on
//                the corelet: kernel fill, kernel load, gap, activation fill,
//                execute and OFIFO drain, with L0/OFIFO flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [len_bw-1:0] num_vec,
    input  logic              l0_full,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst_q,
    output logic              busy,
    output logic              done
);

    localparam int                 c_cnt_w    = cnt_width(row, col, len_bw);
    localparam logic [c_cnt_w-1:0] c_col_last = c_cnt_w'(col - 1);

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [len_bw-1:0]   r_num_vec;
    logic                w_cnt_inc;
    logic                w_accept;
    logic [c_cnt_w-1:0]  w_nv_last;

    // Last counter value of the num_vec-length phases; r_num_vec is never 0 in those phases
    assign w_nv_last = c_cnt_w'(r_num_vec) - c_cnt_w'(1);

    // A tile is accepted exactly when IDLE moves to KFILL
    assign w_accept  = (r_state == S_IDLE) && (w_next == S_KFILL);

    // State, shared phase counter and latched vector count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_num_vec <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_accept) begin
                r_num_vec <= num_vec;
            end
        end
    end

    // Next-state and instruction decode; outputs depend only on state, counter and flow control
    always_comb begin
        w_next    = r_state;
        w_cnt_inc = 1'b0;
        inst_q    = '0;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (num_vec != '0)) begin
                    w_next = S_KFILL;
                end
            end
            S_KFILL: begin
                inst_q[L0_WR] = ~l0_full;
                w_cnt_inc     = ~l0_full;
                if (!l0_full && (r_cnt == c_col_last)) begin
                    w_next = S_KLOAD;
                end
            end
            S_KLOAD: begin
                inst_q[L0_RD] = 1'b1;
                inst_q[LOAD]  = 1'b1;
                w_cnt_inc     = 1'b1;
                if (r_cnt == c_col_last) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                w_next = S_AFILL;
            end
            S_AFILL: begin
                inst_q[L0_WR] = ~l0_full;
                w_cnt_inc     = ~l0_full;
                if (!l0_full && (r_cnt == w_nv_last)) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                inst_q[L0_RD] = 1'b1;
                inst_q[EXEC]  = 1'b1;
                w_cnt_inc     = 1'b1;
                if (r_cnt == w_nv_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                inst_q[OFIFO_RD] = ofifo_valid;
                w_cnt_inc        = ofifo_valid;
                if (ofifo_valid && (r_cnt == w_nv_last)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_sequencer
//  Description : Self-checking bench for inst_sequencer; a phase-list model
//                predicts inst_q/busy/done every cycle under random and
//                directed flow-control stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_sequencer;

    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int LEN_BW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_BW-1:0] num_vec;
    logic              l0_full;
    logic              ofifo_valid;
    logic [33:0]       inst_q;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_sequencer #(.row(ROW), .col(COL), .len_bw(LEN_BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_vec     (num_vec),
        .l0_full     (l0_full),
        .ofifo_valid (ofifo_valid),
        .inst_q      (inst_q),
        .busy        (busy),
        .done        (done)
    );

    // Cycles from the start cycle through the done cycle, both inclusive, with no stalls
    function automatic int nominal_len(input int nv);
        return 1 + COL + COL + 1 + nv + nv + nv + 1;
    endfunction

    // Runs one tile from IDLE and checks every cycle against a phase-list model.
    // mode: 0 no stalls, 1 l0_full on KFILL cycles 3/4, 2 ofifo 1,0,1,0 in DRAIN, 3 random.
    task automatic run_tile(input int nv, input int mode, input bit pulse,
                            output int lat_done, output int lat_load, output int n_wr);
        int          seg_n[7];
        int          si, p, lat, cyc, kcyc, dcyc;
        bit          adv, prev_done;
        logic [33:0] exp_q;
        logic        exp_done;
        // phases: 0 kfill, 1 kload, 2 gap, 3 afill, 4 exec, 5 drain, 6 done
        seg_n     = '{COL, COL, 1, nv, nv, nv, 1};
        lat_done  = -1;
        lat_load  = -1;
        n_wr      = 0;
        prev_done = 1'b0;
        start       = 1'b1;
        num_vec     = LEN_BW'(nv);
        l0_full     = 1'b0;
        ofifo_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || inst_q !== 34'h0) begin
            n_fail++;
            $display("FAIL idle_at_start: busy=%b done=%b inst_q=%h, expected 0 0 0", busy, done, inst_q);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        si = 0; p = 0; lat = 1; cyc = 0; kcyc = 0; dcyc = 0;
        while (si < 7 && cyc < 4000) begin
            num_vec = LEN_BW'($urandom);
            case (mode)
                0: begin
                    l0_full     = 1'b0;
                    ofifo_valid = 1'b1;
                end
                1: begin
                    if (si == 0) kcyc++;
                    l0_full     = (si == 0) && (kcyc == 3 || kcyc == 4);
                    ofifo_valid = 1'b1;
                end
                2: begin
                    if (si == 5) dcyc++;
                    l0_full     = 1'b0;
                    ofifo_valid = (si != 5) || (dcyc % 2 == 1);
                end
                default: begin
                    l0_full     = ($urandom % 3 == 0);
                    ofifo_valid = 1'($urandom);
                end
            endcase
            if (pulse && ((si == 4 && p == 0) || si == 6)) begin
                start   = 1'b1;
                num_vec = LEN_BW'($urandom_range(1, 255));
            end
            @(negedge clk);
            lat++;
            exp_q    = '0;
            exp_done = 1'b0;
            adv      = 1'b1;
            case (si)
                0, 3: begin exp_q[2] = ~l0_full; adv = ~l0_full; end
                1:    begin exp_q[0] = 1'b1; exp_q[3] = 1'b1; end
                2:    begin end
                4:    begin exp_q[1] = 1'b1; exp_q[3] = 1'b1; end
                5:    begin exp_q[6] = ofifo_valid; adv = ofifo_valid; end
                default: exp_done = 1'b1;
            endcase
            n_checks++;
            if (inst_q !== exp_q) begin
                n_fail++;
                $display("FAIL inst_q phase=%0d step=%0d: got %h, expected %h", si, p, inst_q, exp_q);
            end
            n_checks++;
            if (busy !== 1'b1 || done !== exp_done) begin
                n_fail++;
                $display("FAIL busy_done phase=%0d: got busy=%b done=%b, expected 1 %b", si, busy, done, exp_done);
            end
            n_checks++;
            if ((inst_q[0] && inst_q[1]) || (inst_q[2] && inst_q[3])) begin
                n_fail++;
                $display("FAIL exclusive_bits: inst_q=%h has load+exec or wr+rd together", inst_q);
            end
            n_checks++;
            if (inst_q[5:4] !== 2'b00 || inst_q[33:7] !== 27'h0) begin
                n_fail++;
                $display("FAIL reserved_bits: inst_q=%h, expected bits [5:4] and [33:7] zero", inst_q);
            end
            n_checks++;
            if (prev_done && done) begin
                n_fail++;
                $display("FAIL done_width: done high 2 cycles in a row, expected single pulse");
            end
            prev_done = done;
            if (inst_q[2] === 1'b1) n_wr++;
            if (inst_q[0] === 1'b1 && lat_load < 0) lat_load = lat;
            if (done === 1'b1 && lat_done < 0) lat_done = lat;
            if (adv) begin
                p++;
                if (p == seg_n[si]) begin
                    si++;
                    p = 0;
                end
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        if (si < 7) begin
            n_checks++;
            n_fail++;
            $display("FAIL tile_timeout: phase=%0d after %0d cycles, expected tile to finish", si, cyc);
        end
        l0_full     = 1'b0;
        ofifo_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || inst_q !== 34'h0) begin
                n_fail++;
                $display("FAIL idle_after_tile: busy=%b done=%b inst_q=%h, expected 0 0 0", busy, done, inst_q);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        start       = 1'b0;
        num_vec     = '0;
        l0_full     = 1'b0;
        ofifo_valid = 1'b1;
        repeat (2) @(posedge clk);
        start   = 1'b1;
        num_vec = 8'd5;
        @(negedge clk);
        n_checks++;
        if (inst_q !== 34'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: inst_q=%h busy=%b done=%b, expected 0 0 0", inst_q, busy, done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_holds_idle: busy=%b, expected 0", busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_nominal();
        int ld, ll, nw;
        run_tile(4, 0, 1'b0, ld, ll, nw);
        n_checks++;
        if (ld != nominal_len(4)) begin
            n_fail++;
            $display("FAIL nominal_latency: done at cycle %0d, expected %0d", ld, nominal_len(4));
        end
        n_checks++;
        if (ll != 1 + COL + 1) begin
            n_fail++;
            $display("FAIL nominal_kload_entry: at cycle %0d, expected %0d", ll, 1 + COL + 1);
        end
        n_checks++;
        if (nw != COL + 4) begin
            n_fail++;
            $display("FAIL nominal_writes: got %0d, expected %0d", nw, COL + 4);
        end
    endtask

    task automatic test_l0_backpressure();
        int ld, ll, nw;
        run_tile(4, 1, 1'b0, ld, ll, nw);
        n_checks++;
        if (ll != 1 + COL + 1 + 2) begin
            n_fail++;
            $display("FAIL bp_kload_entry: at cycle %0d, expected %0d", ll, 1 + COL + 1 + 2);
        end
        n_checks++;
        if (nw != COL + 4) begin
            n_fail++;
            $display("FAIL bp_writes: got %0d, expected %0d", nw, COL + 4);
        end
        n_checks++;
        if (ld != nominal_len(4) + 2) begin
            n_fail++;
            $display("FAIL bp_latency: done at cycle %0d, expected %0d", ld, nominal_len(4) + 2);
        end
    endtask

    task automatic test_ofifo_starvation();
        int ld, ll, nw;
        run_tile(2, 2, 1'b0, ld, ll, nw);
        n_checks++;
        if (ld != nominal_len(2) + 1) begin
            n_fail++;
            $display("FAIL starve_latency: done at cycle %0d, expected %0d", ld, nominal_len(2) + 1);
        end
    endtask

    task automatic test_ignored_starts();
        int ld, ll, nw;
        start   = 1'b1;
        num_vec = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || inst_q !== 34'h0) begin
            n_fail++;
            $display("FAIL zero_vec_start: busy=%b inst_q=%h, expected 0 0", busy, inst_q);
        end
        @(posedge clk);
        #1;
        run_tile(3, 0, 1'b1, ld, ll, nw);
        n_checks++;
        if (ld != nominal_len(3)) begin
            n_fail++;
            $display("FAIL pulse_latency: done at cycle %0d, expected %0d", ld, nominal_len(3));
        end
    endtask

    task automatic test_reset_mid_exec();
        int ld, ll, nw;
        start       = 1'b1;
        num_vec     = 8'd4;
        l0_full     = 1'b0;
        ofifo_valid = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // 8 kfill + 8 kload + 1 gap + 4 afill edges, then 2 into exec
        repeat (22) @(posedge clk);
        #1;
        n_checks++;
        if (inst_q !== 34'h00A || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_exec: inst_q=%h busy=%b, expected 00a 1", inst_q, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (inst_q !== 34'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: inst_q=%h busy=%b done=%b, expected 0 0 0", inst_q, busy, done);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_tile(3, 0, 1'b0, ld, ll, nw);
        n_checks++;
        if (ld != nominal_len(3)) begin
            n_fail++;
            $display("FAIL post_reset_latency: done at cycle %0d, expected %0d", ld, nominal_len(3));
        end
    endtask

    task automatic test_boundary();
        int ld, ll, nw;
        run_tile(1, 0, 1'b0, ld, ll, nw);
        n_checks++;
        if (ld != nominal_len(1)) begin
            n_fail++;
            $display("FAIL nv1_latency: done at cycle %0d, expected %0d", ld, nominal_len(1));
        end
        run_tile(255, 0, 1'b0, ld, ll, nw);
        n_checks++;
        if (ld != nominal_len(255)) begin
            n_fail++;
            $display("FAIL nv255_latency: done at cycle %0d, expected %0d", ld, nominal_len(255));
        end
    endtask

    task automatic test_random();
        int ld, ll, nw, nv;
        for (int i = 0; i < 10; i++) begin
            nv = $urandom_range(1, 12);
            run_tile(nv, 3, 1'($urandom), ld, ll, nw);
            n_checks++;
            if (nw != COL + nv) begin
                n_fail++;
                $display("FAIL random_writes tile=%0d: got %0d, expected %0d", i, nw, COL + nv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_l0_backpressure();
        test_ofifo_starvation();
        test_ignored_starts();
        test_reset_mid_exec();
        test_boundary();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
